distribucion_salida_n: RTL and testbench



---
 rtl/distribucion_pkg.sv | 13 +
 rtl/distribucion_salida_n_contador_tiempo_muerto.sv | 41 ++++
 rtl/distribucion_salida_n.sv | 123 ++++++++++++
 tb/tb_distribucion_salida_n.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/distribucion_pkg.sv
// Shared types and constants for the switching-signal distributor.
package distribucion_pkg;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        ACTIVO   = 2'd1,
        MUERTO   = 2'd2
    } estado_t;

    localparam int CONT_W      = 8;
    localparam int MAX_CANALES = 16;

endpackage

// File: rtl/distribucion_salida_n_contador_tiempo_muerto.sv
// Loadable dead-time down-counter; done marks the last dead cycle (value == 1).
module contador_tiempo_muerto
    import distribucion_pkg::*;
#(
    parameter int W = CONT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (clear) begin
            value_d = '0;
        end else if (value_q != '0) begin
            value_d = value_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign done  = (value_q == W'(1));

endmodule

// File: rtl/distribucion_salida_n.sv
// Routes one switching signal to one of NUM_CANALES registered outputs with break-before-make dead time.
// Optional macro SYNC_ENTRADA_EN adds a 2-flop input synchroniser (latency 3 instead of 1).
module distribucion_salida_n
    import distribucion_pkg::*;
#(
    parameter int NUM_CANALES   = 4,
    parameter int SEL_W         = $clog2(NUM_CANALES),
    parameter int TIEMPO_MUERTO = 8,
    parameter int CANAL_RESET   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   in_signal_conmutacion,
    input  logic [SEL_W-1:0]       select_salida,
    input  logic                   sel_valid,
    output logic [NUM_CANALES-1:0] out_signal_conmutacion,
    output logic [SEL_W-1:0]       canal_activo,
    output logic                   busy,
    output logic                   sel_error
);

    estado_t                estado_q, estado_d;
    logic [SEL_W-1:0]       canal_q, canal_d;
    logic [NUM_CANALES-1:0] out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   sel_error_q, sel_error_d;
    logic                   in_eff;
    logic                   sel_ok;
    logic                   cont_load, cont_clear, cont_done;
    logic [CONT_W-1:0]      cont_value;

`ifdef SYNC_ENTRADA_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], in_signal_conmutacion};
        end
    end

    assign in_eff = sync_q[1];
`else
    assign in_eff = in_signal_conmutacion;
`endif

    contador_tiempo_muerto #(.W(CONT_W)) u_contador (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cont_load),
        .clear      (cont_clear),
        .load_value (CONT_W'(TIEMPO_MUERTO)),
        .value      (cont_value),
        .done       (cont_done)
    );

    assign sel_ok = sel_valid && (int'(select_salida) < NUM_CANALES);

    // Outputs are derived from the next state so the new channel appears on the same edge the dead time ends.
    always_comb begin
        estado_d    = estado_q;
        canal_d     = canal_q;
        cont_load   = 1'b0;
        sel_error_d = sel_valid && !sel_ok;

        if (!enable) begin
            estado_d = INACTIVO;
            if (sel_ok) canal_d = select_salida;
        end else begin
            case (estado_q)
                INACTIVO: begin
                    estado_d = ACTIVO;
                    if (sel_ok) canal_d = select_salida;
                end
                ACTIVO: begin
                    if (sel_ok && (select_salida != canal_q)) begin
                        canal_d   = select_salida;
                        cont_load = 1'b1;
                        estado_d  = MUERTO;
                    end
                end
                MUERTO: begin
                    if (sel_ok) begin
                        canal_d   = select_salida;
                        cont_load = 1'b1;
                    end else if (cont_done || (cont_value == '0)) begin
                        estado_d = ACTIVO;
                    end
                end
                default: estado_d = INACTIVO;
            endcase
        end

        cont_clear = (estado_d != MUERTO);
        busy_d     = (estado_d == MUERTO);
        out_d      = '0;
        if (estado_d == ACTIVO) out_d[canal_d] = in_eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= INACTIVO;
            canal_q     <= SEL_W'(CANAL_RESET);
            out_q       <= '0;
            busy_q      <= 1'b0;
            sel_error_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            canal_q     <= canal_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            sel_error_q <= sel_error_d;
        end
    end

    assign out_signal_conmutacion = out_q;
    assign canal_activo           = canal_q;
    assign busy                   = busy_q;
    assign sel_error              = sel_error_q;

endmodule

// File: tb/tb_distribucion_salida_n.sv
// Scoreboard bench for distribucion_salida_n: a dead-time window model predicts every output cycle.
module tb_distribucion_salida_n;

    localparam int N     = 5;
    localparam int SW    = $clog2(N);
    localparam int TM    = 8;
    localparam int CRST  = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          in_sig = 1'b0;
    logic [SW-1:0] select_salida = '0;
    logic          sel_valid = 1'b0;
    logic [N-1:0]  out_sig;
    logic [SW-1:0] canal_activo;
    logic          busy;
    logic          sel_error;

    typedef struct {
        int out;
        int canal;
        int busy;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: distribution on/off, target channel, first cycle allowed to drive after a change.
    int   cyc = 0;
    bit   m_on = 0;
    int   m_canal = CRST;
    int   m_dead_until = 0;
    bit   m_hist1 = 0;
    bit   m_hist2 = 0;

    distribucion_salida_n #(
        .NUM_CANALES   (N),
        .TIEMPO_MUERTO (TM),
        .CANAL_RESET   (CRST)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .enable                 (enable),
        .in_signal_conmutacion  (in_sig),
        .select_salida          (select_salida),
        .sel_valid              (sel_valid),
        .out_signal_conmutacion (out_sig),
        .canal_activo           (canal_activo),
        .busy                   (busy),
        .sel_error              (sel_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit inb, input bit sv, input int sel);
        exp_t e;
        bit   in_eff;
        bit   ok;
        bit   b;
        @(negedge clk);
        enable        = en;
        in_sig        = inb;
        sel_valid     = sv;
        select_salida = SW'(sel);
`ifdef SYNC_ENTRADA_EN
        in_eff = m_hist2;
`else
        in_eff = inb;
`endif
        m_hist2 = m_hist1;
        m_hist1 = inb;
        ok = sv && (sel < N);
        if (!en) begin
            m_on = 0;
            if (ok) m_canal = sel;
            m_dead_until = 0;
        end else if (!m_on) begin
            m_on = 1;
            if (ok) m_canal = sel;
            m_dead_until = 0;
        end else if (ok && ((cyc < m_dead_until) || (sel != m_canal))) begin
            m_canal = sel;
            m_dead_until = cyc + TM + 1;
        end
        b       = en && ((cyc + 1) < m_dead_until);
        e.busy  = int'(b);
        e.out   = (en && !b) ? (int'(in_eff) << m_canal) : 0;
        e.canal = m_canal;
        e.err   = int'(sv && (sel >= N));
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_out", int'(out_sig), 0);
        checkOutput("reset_canal", int'(canal_activo), CRST);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_err", int'(sel_error), 0);
        enable    = 1'b0;
        in_sig    = 1'b0;
        sel_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_on = 0;
        m_canal = CRST;
        m_dead_until = 0;
        m_hist1 = 0;
        m_hist2 = 0;
    endtask

    // Monitor: pops one expectation per output cycle and checks the one-hot invariant every cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            total++;
            if ($countones(out_sig) > 1) begin
                bad++;
                $display("[TB] FAIL one_hot: out=%b has %0d bits set, allowed 1", out_sig, $countones(out_sig));
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("out", int'(out_sig), e.out);
                checkOutput("canal", int'(canal_activo), e.canal);
                checkOutput("busy", int'(busy), e.busy);
                checkOutput("sel_error", int'(sel_error), e.err);
            end
        end
    end

    initial begin
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, i[0], 0, 0);
        applyStimulus(1, 1, 1, 2);
        for (int i = 0; i < 12; i++) applyStimulus(1, ~i[0], 0, 0);
        applyStimulus(1, 1, 1, 5);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1, 2);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, i[0], 0, 0);
        applyStimulus(1, 1, 1, 3);
        applyStimulus(1, 0, 1, 7);
        for (int i = 0; i < 14; i++) applyStimulus(1, i[0], 0, 0);
        applyStimulus(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, i[0], 0, 0);
        applyStimulus(1, 1, 1, 4);
        applyStimulus(0, 1, 1, 3);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 1, 4);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 19) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
                          int'($urandom_range(0, 7)));
        end
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
